// File: rtl/flag_table.sv
// Flag table with multi-port registered reads, write-first bypass and a swept clear.
// Define FLAG_TABLE_OCC_COUNT_EN to build the occupancy counter; otherwise occ_count is 0.
module flag_table #(
    parameter int ADDR_W      = 10,
    parameter int FLAG_W      = 2,
    parameter int NUM_RD      = 2,
    parameter int CLR_PER_CYC = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [NUM_RD*ADDR_W-1:0] rd_adr,
    output logic [NUM_RD*FLAG_W-1:0] rd_flag,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_adr,
    input  logic [FLAG_W-1:0]        wr_flag,
    output logic                     wr_ready,
    input  logic                     clear_req,
    output logic                     busy,
    output logic                     clear_done,
    output logic [ADDR_W:0]          occ_count,
    output logic                     dbg_state
);

    localparam int DEPTH = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] PTR_STEP = ADDR_W'(CLR_PER_CYC);
    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - CLR_PER_CYC);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_e;

    state_e                     state_q, state_d;
    logic [ADDR_W-1:0]          ptr_q, ptr_d;
    logic [NUM_RD*FLAG_W-1:0]   rd_flag_q, rd_flag_d;
    logic [FLAG_W-1:0]          mem_q [DEPTH];
    logic                       wr_accept;

    assign busy       = (state_q == ST_CLEAR);
    assign wr_ready   = ~busy;
    assign clear_done = busy && (ptr_q == LAST_PTR);
    assign dbg_state  = (state_q == ST_CLEAR);
    assign rd_flag    = rd_flag_q;
    // A clear request wins over a write presented in the same cycle.
    assign wr_accept  = wr_en && !busy && !clear_req;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (clear_req) begin
                    state_d = ST_CLEAR;
                    ptr_d   = '0;
                end
            end
            ST_CLEAR: begin
                ptr_d = ptr_q + PTR_STEP;
                if (ptr_q == LAST_PTR) begin
                    state_d = ST_IDLE;
                    ptr_d   = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        rd_flag_d = '0;
        if (!busy) begin
            for (int i = 0; i < NUM_RD; i++) begin
                if (wr_accept && (wr_adr == rd_adr[i*ADDR_W +: ADDR_W]))
                    rd_flag_d[i*FLAG_W +: FLAG_W] = wr_flag;
                else
                    rd_flag_d[i*FLAG_W +: FLAG_W] = mem_q[rd_adr[i*ADDR_W +: ADDR_W]];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_CLEAR;
            ptr_q     <= '0;
            rd_flag_q <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            rd_flag_q <= rd_flag_d;
        end
    end

    // Storage has no reset; the sweep that follows reset zeroes it.
    always_ff @(posedge clk) begin
        if (busy) begin
            for (int j = 0; j < CLR_PER_CYC; j++)
                mem_q[ptr_q | ADDR_W'(j)] <= '0;
        end else if (wr_accept) begin
            mem_q[wr_adr] <= wr_flag;
        end
    end

`ifdef FLAG_TABLE_OCC_COUNT_EN
    localparam logic [ADDR_W:0] OCC_MAX = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] OCC_ONE = (ADDR_W+1)'(1);

    logic [ADDR_W:0]   occ_q, occ_d;
    logic [FLAG_W-1:0] old_flag;

    always_comb begin
        old_flag = mem_q[wr_adr];
        occ_d    = occ_q;
        // Zeroing on the request edge makes the count read 0 from the first sweep cycle.
        if (busy || clear_req) begin
            occ_d = '0;
        end else if (wr_accept) begin
            if ((old_flag == '0) && (wr_flag != '0) && (occ_q != OCC_MAX))
                occ_d = occ_q + OCC_ONE;
            else if ((old_flag != '0) && (wr_flag == '0) && (occ_q != '0))
                occ_d = occ_q - OCC_ONE;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            occ_q <= '0;
        else
            occ_q <= occ_d;
    end

    assign occ_count = occ_q;
`else
    assign occ_count = '0;
`endif

endmodule

// File: tb/tb_flag_table.sv
// Directed bench for flag_table at ADDR_W=4, FLAG_W=2, NUM_RD=2, CLR_PER_CYC=4.
module tb_flag_table;

    logic        clk;
    logic        reset_n;
    logic [7:0]  rd_adr;
    logic [3:0]  rd_flag;
    logic        wr_en;
    logic [3:0]  wr_adr;
    logic [1:0]  wr_flag;
    logic        wr_ready;
    logic        clear_req;
    logic        busy;
    logic        clear_done;
    logic [4:0]  occ_count;
    logic        dbg_state;

    int checks = 0;
    int errors = 0;

    flag_table #(
        .ADDR_W(4), .FLAG_W(2), .NUM_RD(2), .CLR_PER_CYC(4)
    ) dut (
        .clk(clk), .reset_n(reset_n), .rd_adr(rd_adr), .rd_flag(rd_flag),
        .wr_en(wr_en), .wr_adr(wr_adr), .wr_flag(wr_flag), .wr_ready(wr_ready),
        .clear_req(clear_req), .busy(busy), .clear_done(clear_done),
        .occ_count(occ_count), .dbg_state(dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       wr_en;
        logic [3:0] wr_adr;
        logic [1:0] wr_flag;
        logic [3:0] rd0;
        logic [3:0] rd1;
        logic [1:0] exp0;
        logic [1:0] exp1;
        int         exp_occ;
    } vec_t;

    vec_t vecs[11];

    function automatic int occ_exp(input int n);
`ifdef FLAG_TABLE_OCC_COUNT_EN
        return n;
`else
        return 0;
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic read_all_zero(input string name);
        wr_en = 1'b0;
        for (int a = 0; a < 16; a++) begin
            rd_adr = {a[3:0], a[3:0]};
            cycle();
            check(name, {28'd0, rd_flag}, 32'd0);
        end
    endtask

    task automatic sweep_check(input string name);
        for (int k = 0; k < 4; k++) begin
            check({name, "_busy"}, {31'd0, busy}, 32'd1);
            check({name, "_done"}, {31'd0, clear_done}, (k == 3) ? 32'd1 : 32'd0);
            cycle();
        end
        check({name, "_idle"}, {31'd0, busy}, 32'd0);
        check({name, "_ready"}, {31'd0, wr_ready}, 32'd1);
    endtask

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{1'b1, 4'd5,  2'b01, 4'd0,  4'd0, 2'b00, 2'b00, 1};
        vecs[1]  = '{1'b0, 4'd0,  2'b00, 4'd5,  4'd5, 2'b01, 2'b01, 1};
        vecs[2]  = '{1'b1, 4'd3,  2'b10, 4'd3,  4'd5, 2'b10, 2'b01, 2};
        vecs[3]  = '{1'b1, 4'd7,  2'b11, 4'd7,  4'd3, 2'b11, 2'b10, 3};
        vecs[4]  = '{1'b1, 4'd7,  2'b00, 4'd7,  4'd7, 2'b00, 2'b00, 2};
        vecs[5]  = '{1'b1, 4'd5,  2'b10, 4'd5,  4'd7, 2'b10, 2'b00, 2};
        vecs[6]  = '{1'b1, 4'd9,  2'b00, 4'd9,  4'd3, 2'b00, 2'b10, 2};
        vecs[7]  = '{1'b0, 4'd0,  2'b00, 4'd5,  4'd3, 2'b10, 2'b10, 2};
        vecs[8]  = '{1'b1, 4'd3,  2'b00, 4'd5,  4'd3, 2'b10, 2'b00, 1};
        vecs[9]  = '{1'b1, 4'd15, 2'b01, 4'd15, 4'd0, 2'b01, 2'b00, 2};
        vecs[10] = '{1'b1, 4'd0,  2'b11, 4'd15, 4'd0, 2'b01, 2'b11, 3};

        reset_n = 1'b0; rd_adr = '0; wr_en = 1'b0; wr_adr = '0;
        wr_flag = '0; clear_req = 1'b0;
        repeat (3) cycle();
        check("rst_busy", {31'd0, busy}, 32'd1);
        check("rst_done", {31'd0, clear_done}, 32'd0);
        check("rst_rd", {28'd0, rd_flag}, 32'd0);
        check("rst_occ", {27'd0, occ_count}, 32'd0);

        reset_n = 1'b1;
        sweep_check("init_sweep");
        read_all_zero("init_rd");

        for (int v = 0; v < 11; v++) begin
            wr_en   = vecs[v].wr_en;
            wr_adr  = vecs[v].wr_adr;
            wr_flag = vecs[v].wr_flag;
            rd_adr  = {vecs[v].rd1, vecs[v].rd0};
            cycle();
            check($sformatf("vec%0d_rd", v), {28'd0, rd_flag}, {28'd0, vecs[v].exp1, vecs[v].exp0});
            check($sformatf("vec%0d_occ", v), {27'd0, occ_count}, occ_exp(vecs[v].exp_occ));
        end
        wr_en = 1'b0;

        for (int a = 0; a < 16; a++) begin
            wr_en = 1'b1; wr_adr = a[3:0]; wr_flag = 2'((a % 3) + 1);
            cycle();
        end
        wr_en = 1'b0;
        check("fill_occ", {27'd0, occ_count}, occ_exp(16));

        clear_req = 1'b1; wr_en = 1'b1; wr_adr = 4'd2; wr_flag = 2'b00;
        rd_adr = {4'd2, 4'd2};
        check("clr_req_ready", {31'd0, wr_ready}, 32'd1);
        cycle();
        check("clr_req_rd", {28'd0, rd_flag}, 32'hf);
        check("clr_first_occ", {27'd0, occ_count}, 32'd0);
        clear_req = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check("busy_sweep_busy", {31'd0, busy}, 32'd1);
            check("busy_sweep_done", {31'd0, clear_done}, (k == 3) ? 32'd1 : 32'd0);
            check("busy_sweep_ready", {31'd0, wr_ready}, 32'd0);
            check("busy_sweep_occ", {27'd0, occ_count}, 32'd0);
            if (k > 0) check("busy_sweep_rd", {28'd0, rd_flag}, 32'd0);
            clear_req = (k > 0);
            wr_en = 1'b1; wr_adr = 4'(k); wr_flag = 2'b01;
            rd_adr = {4'(k), 4'(k)};
            cycle();
        end
        clear_req = 1'b0; wr_en = 1'b0;
        check("after_clr_busy", {31'd0, busy}, 32'd0);
        check("after_clr_rd", {28'd0, rd_flag}, 32'd0);
        check("after_clr_occ", {27'd0, occ_count}, 32'd0);
        read_all_zero("after_clr_tbl");

        wr_en = 1'b1; wr_adr = 4'd7; wr_flag = 2'b11;
        cycle();
        check("rw7_occ_up", {27'd0, occ_count}, occ_exp(1));
        wr_flag = 2'b00;
        cycle();
        check("rw7_occ_down", {27'd0, occ_count}, occ_exp(0));
        wr_en = 1'b0; rd_adr = {4'd7, 4'd7};
        cycle();
        check("rw7_rd", {28'd0, rd_flag}, 32'd0);

        wr_en = 1'b1; wr_adr = 4'd12; wr_flag = 2'b10;
        cycle();
        wr_en = 1'b0; clear_req = 1'b1;
        cycle();
        clear_req = 1'b0;
        cycle();
        reset_n = 1'b0;
        cycle();
        cycle();
        check("midrst_busy", {31'd0, busy}, 32'd1);
        check("midrst_done", {31'd0, clear_done}, 32'd0);
        check("midrst_occ", {27'd0, occ_count}, 32'd0);
        reset_n = 1'b1;
        sweep_check("midrst_sweep");
        rd_adr = {4'd0, 4'd12};
        cycle();
        check("midrst_rd", {28'd0, rd_flag}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
